// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_pkg
//  Description : Shared RV32I load/store encodings, LSU state type and
//                legality/alignment helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

    localparam int XLEN   = 32;
    localparam int STRB_W = XLEN / 8;

    // funct3 width/sign codes shared by loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUS  = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_t;

    // Stores only have signed-less B/H/W; loads add the unsigned B/H variants.
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!is_store) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

    // funct3[1:0] encodes the access size: 00 byte, 01 half, 10 word.
    function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        case (f3[1:0])
            2'b01:   ok = ~off[0];
            2'b10:   ok = (off == 2'b00);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_format.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_load_format
//  Description : Extracts the addressed byte/half from a bus read word and
//                sign- or zero-extends it to 32 bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_format
    import rv32i_pkg::*;
(
    input  logic [XLEN-1:0] bus_rdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select followed by width/sign extension
    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = bus_rdata[7:0];
            2'd1:    byte_sel = bus_rdata[15:8];
            2'd2:    byte_sel = bus_rdata[23:16];
            default: byte_sel = bus_rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];

        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            F3_W:    load_data = bus_rdata;
            default: load_data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : RV32I data-memory access unit. Issues one valid/ready bus
//                transaction per load/store, stalls the core while it is
//                outstanding, and formats load data for writeback.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import rv32i_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   address,
    input  logic [XLEN-1:0]   write_data,
    output logic [XLEN-1:0]   read_data,
    output logic              stall,
    output logic              lsu_exception,
    output logic              bus_error,
    output logic              bus_req,
    output logic              bus_we,
    output logic [XLEN-1:0]   bus_addr,
    output logic [XLEN-1:0]   bus_wdata,
    output logic [STRB_W-1:0] bus_wstrb,
    input  logic              bus_ready,
    input  logic [XLEN-1:0]   bus_rdata
);

    // Counter value seen in the last permitted BUS cycle: the counter starts
    // at 0 in the first BUS cycle, so TIMEOUT_CYCLES BUS cycles end here.
    localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   read_data_q, read_data_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [XLEN-1:0]   bus_addr_q, bus_addr_d;
    logic [XLEN-1:0]   bus_wdata_q, bus_wdata_d;
    logic [STRB_W-1:0] bus_wstrb_q, bus_wstrb_d;
    logic              bus_error_q, bus_error_d;
    logic [2:0]        fmt_f3_q, fmt_f3_d;
    logic [1:0]        fmt_off_q, fmt_off_d;

    logic              req;
    logic              legal;
    logic [XLEN-1:0]   lane_wdata;
    logic [STRB_W-1:0] lane_wstrb;
    logic [XLEN-1:0]   fmt_data;

    lsu_load_format u_load_format (
        .bus_rdata (bus_rdata),
        .funct3    (fmt_f3_q),
        .addr_lo   (fmt_off_q),
        .load_data (fmt_data)
    );

    // Request decode: legality check and store lane replication/byte enables
    always_comb begin
        req   = mem_read | mem_write;
        // mem_write selects store legality, so a store wins when both are set
        legal = f3_legal(funct3, mem_write) && f3_aligned(funct3, address[1:0]);
        case (funct3)
            F3_B: begin
                lane_wdata = {4{write_data[7:0]}};
                lane_wstrb = 4'b0001 << address[1:0];
            end
            F3_H: begin
                lane_wdata = {2{write_data[15:0]}};
                lane_wstrb = 4'b0011 << address[1:0];
            end
            default: begin
                lane_wdata = write_data;
                lane_wstrb = 4'b1111;
            end
        endcase
        if (!mem_write) begin
            lane_wstrb = 4'b0000;
        end
    end

    // Next-state, stall and exception logic of the IDLE/BUS/DONE sequencer
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        read_data_d   = read_data_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        bus_wstrb_d   = bus_wstrb_q;
        bus_error_d   = 1'b0;
        fmt_f3_d      = fmt_f3_q;
        fmt_off_d     = fmt_off_q;
        stall         = 1'b0;
        lsu_exception = 1'b0;

        case (state_q)
            LSU_IDLE: begin
                if (req) begin
                    if (!legal) begin
                        // Trap immediately; the core must not wait on the bus
                        lsu_exception = rst_n;
                        read_data_d   = '0;
                    end else begin
                        stall       = 1'b1;
                        bus_req_d   = 1'b1;
                        bus_we_d    = mem_write;
                        bus_addr_d  = {address[31:2], 2'b00};
                        bus_wdata_d = lane_wdata;
                        bus_wstrb_d = lane_wstrb;
                        fmt_f3_d    = funct3;
                        fmt_off_d   = address[1:0];
                        cnt_d       = '0;
                        state_d     = LSU_BUS;
                    end
                end
            end
            LSU_BUS: begin
                stall = 1'b1;
                if (bus_ready) begin
                    if (!bus_we_q) begin
                        read_data_d = fmt_data;
                    end
                    bus_req_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = LSU_DONE;
                end else if (cnt_q == C_TIMEOUT_LAST) begin
                    bus_req_d   = 1'b0;
                    read_data_d = '0;
                    bus_error_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = LSU_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LSU_DONE: begin
                // Retire cycle; inputs still show the same instruction, so
                // they are deliberately not looked at here.
                state_d = LSU_IDLE;
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
    end

    // State and bus-side registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= LSU_IDLE;
            cnt_q       <= '0;
            read_data_q <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wstrb_q <= '0;
            bus_error_q <= 1'b0;
            fmt_f3_q    <= '0;
            fmt_off_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            read_data_q <= read_data_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wstrb_q <= bus_wstrb_d;
            bus_error_q <= bus_error_d;
            fmt_f3_q    <= fmt_f3_d;
            fmt_off_q   <= fmt_off_d;
        end
    end

    assign read_data = read_data_q;
    assign bus_error = bus_error_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wstrb = bus_wstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Randomized scoreboard bench for load_store_unit with a
//                behavioural memory-access model and a latency-programmable
//                bus responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int TIMEOUT = 16;
    localparam int K_EXC   = 0;
    localparam int K_REQ   = 1;
    localparam int K_DONE  = 2;

    logic        clk;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] address, write_data, read_data;
    logic        stall, lsu_exception, bus_error, bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ready;

    load_store_unit #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .address(address), .write_data(write_data),
        .read_data(read_data), .stall(stall), .lsu_exception(lsu_exception),
        .bus_error(bus_error), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        chk_wdata;
        logic [31:0] rd;
        logic        err;
        int          cycles;
    } exp_t;

    exp_t        exp_q[$];
    int          checks;
    int          failures;
    logic [31:0] model_rd;
    int          resp_lat;
    logic [31:0] resp_data;
    logic        resp_never;
    logic [2:0]  legal_load [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Reference load result: pick the addressed bytes arithmetically, then extend
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * int'(off))) & 32'hFF;
        h = (w >> (16 * int'(off >> 1))) & 32'hFFFF;
        case (f3)
            3'd0:    return 32'(b) + ((b >= 128) ? 32'hFFFF_FF00 : 32'd0);
            3'd4:    return 32'(b);
            3'd1:    return 32'(h) + ((h >= 32768) ? 32'hFFFF_0000 : 32'd0);
            3'd5:    return 32'(h);
            default: return w;
        endcase
    endfunction

    // Bus responder: grants after resp_lat idle BUS cycles unless told never to
    initial begin : responder
        int wait_cnt;
        wait_cnt  = 0;
        bus_ready = 1'b0;
        bus_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus_ready = 1'b0;
            bus_rdata = $urandom;
            if (bus_req === 1'b1 && rst_n) begin
                if (!resp_never && wait_cnt >= resp_lat) begin
                    bus_ready = 1'b1;
                    bus_rdata = resp_data;
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: detects bus start, completion and exception events and scores them
    initial begin : monitor
        logic prev_req;
        int   bus_cycles;
        exp_t e;
        logic done_evt;
        prev_req   = 1'b0;
        bus_cycles = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req   = 1'b0;
                bus_cycles = 0;
            end else begin
                done_evt = 1'b0;
                if (bus_req === 1'b1) begin
                    if (!prev_req) begin
                        if (exp_q.size() == 0) begin
                            checks++; failures++;
                            $display("FAIL unexpected_req actual=bus_req required=no_event");
                        end else begin
                            e = exp_q.pop_front();
                            check("req_kind", e.kind, K_REQ);
                            check("bus_we", bus_we, e.we);
                            check("bus_addr", bus_addr, e.addr);
                            check("bus_wstrb", bus_wstrb, e.wstrb);
                            if (e.chk_wdata) check("bus_wdata", bus_wdata, e.wdata);
                        end
                    end
                    bus_cycles++;
                    check("bus_stall", stall, 1);
                end else if (prev_req) begin
                    done_evt = 1'b1;
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_done actual=done required=no_event");
                    end else begin
                        e = exp_q.pop_front();
                        check("done_kind", e.kind, K_DONE);
                        check("done_read_data", read_data, e.rd);
                        check("done_bus_error", bus_error, e.err);
                        check("done_stall", stall, 0);
                        check("bus_req_cycles", bus_cycles, e.cycles);
                    end
                    bus_cycles = 0;
                end
                if (lsu_exception === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_exc actual=lsu_exception required=no_event");
                    end else begin
                        e = exp_q.pop_front();
                        check("exc_kind", e.kind, K_EXC);
                        check("exc_stall", stall, 0);
                        check("exc_bus_req", bus_req, 0);
                    end
                end
                if (!done_evt) check("bus_error_quiet", bus_error, 0);
                prev_req = (bus_req === 1'b1);
            end
        end
    end

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        mem_read = rd; mem_write = wr; funct3 = f3; address = a; write_data = wd;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input int lat,
                         input logic [31:0] rdata, input logic never, input logic abort);
        exp_t        e;
        int unsigned size, off;
        logic        ok;
        int          n;
        e = '{default: 0};
        size = 1 << (int'(f3) & 3);
        off  = a % 4;
        ok = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (ok) ok = ((a % size) == 0);
        if (!ok) begin
            e.kind = K_EXC;
            exp_q.push_back(e);
            model_rd = '0;
            drive(rd, wr, f3, a, wd);
            #1 check("exc_stall_comb", stall, 0);
            @(posedge clk); #1;
            drive(0, 0, 3'd0, 32'd0, 32'd0);
            return;
        end
        e.kind = K_REQ;
        e.we   = wr;
        e.addr = a - off;
        if (wr) begin
            e.chk_wdata = 1'b1;
            e.wstrb = (size == 4) ? 4'hF : 4'(((1 << size) - 1) << off);
            for (int i = 0; i < 4; i++)
                e.wdata[8*i +: 8] = wd[8*(i % int'(size)) +: 8];
        end else begin
            e.wstrb = 4'h0;
        end
        exp_q.push_back(e);
        if (!abort) begin
            e.kind   = K_DONE;
            e.rd     = never ? 32'd0 : (wr ? model_rd : ref_load(f3, 2'(off), rdata));
            e.err    = never;
            e.cycles = never ? TIMEOUT : lat + 1;
            exp_q.push_back(e);
            model_rd = e.rd;
        end
        resp_lat = lat; resp_data = rdata; resp_never = never;
        drive(rd, wr, f3, a, wd);
        #1 check("req_stall_comb", stall, 1);
        if (abort) begin
            repeat (2) begin @(posedge clk); #1; end
            rst_n = 1'b0;
            drive(0, 0, 3'd0, 32'd0, 32'd0);
            @(posedge clk); #1;
            rst_n = 1'b1;
            model_rd = '0;
            check("rst_mid_bus_req", bus_req, 0);
            check("rst_mid_stall", stall, 0);
            check("rst_mid_read_data", read_data, 0);
            return;
        end
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (stall && n < 40);
        if (stall) begin
            failures++;
            $display("FAIL wait_done actual=stall_high required=stall_low_within_40");
        end
        checks++;
        // Keep the instruction on the inputs through DONE; it must not re-issue
        @(posedge clk); #1;
        drive(0, 0, 3'd0, 32'd0, 32'd0);
    endtask

    initial begin : stimulus
        logic        rd, wr, never;
        logic [2:0]  f3;
        logic [31:0] a;
        int          sel;
        checks = 0; failures = 0; model_rd = '0;
        resp_lat = 0; resp_data = '0; resp_never = 1'b0;
        rst_n = 1'b0;
        drive(0, 0, 3'd0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_read_data", read_data, 0);
        check("rst_bus_req", bus_req, 0);
        check("rst_bus_we", bus_we, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_wstrb", bus_wstrb, 0);
        check("rst_stall", stall, 0);
        check("rst_bus_error", bus_error, 0);
        check("rst_exc", lsu_exception, 0);

        issue(1, 0, 3'd2, 32'h100, 32'h0, 0, 32'hDEADBEEF, 0, 0);   // LW
        issue(1, 0, 3'd0, 32'h103, 32'h0, 0, 32'h80FF0000, 0, 0);   // LB
        issue(1, 0, 3'd4, 32'h103, 32'h0, 1, 32'h80FF0000, 0, 0);   // LBU
        issue(1, 0, 3'd5, 32'h102, 32'h0, 2, 32'h80FF0000, 0, 0);   // LHU
        issue(0, 1, 3'd0, 32'h201, 32'hA5, 0, 32'h0, 0, 0);         // SB
        issue(1, 1, 3'd1, 32'h206, 32'h1234BEEF, 1, 32'h0, 0, 0);   // both: SH wins
        issue(1, 0, 3'd2, 32'h102, 32'h0, 0, 32'h0, 0, 0);          // misaligned LW
        issue(1, 0, 3'd3, 32'h100, 32'h0, 0, 32'h0, 0, 0);          // illegal load
        issue(0, 1, 3'd4, 32'h100, 32'h0, 0, 32'h0, 0, 0);          // illegal store
        issue(1, 0, 3'd1, 32'h3FE, 32'h0, 0, 32'h00007F01, 0, 0);   // LH
        issue(1, 0, 3'd2, 32'h300, 32'h0, 0, 32'h0, 1, 0);          // timeout
        issue(1, 0, 3'd2, 32'h400, 32'h0, 5, 32'h0, 0, 1);          // reset mid-BUS
        issue(1, 0, 3'd2, 32'h104, 32'h0, 0, 32'hCAFEF00D, 0, 0);   // recovers

        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 2);
            rd  = (sel != 1);
            wr  = (sel != 0);
            if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
            else if (wr)                   f3 = 3'($urandom_range(0, 2));
            else                           f3 = legal_load[$urandom_range(0, 4)];
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a - (a % (1 << (int'(f3) & 3)));
            never = ($urandom_range(0, 24) == 0);
            issue(rd, wr, f3, a, $urandom, $urandom_range(0, 3), $urandom, never, 0);
        end

        repeat (3) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
